// File: rtl/scan_sequencer.sv
// Scan sequencer: walks the enabled MASK slots in ascending order, driving a
// 2-to-4 decoder with DWELL+1 cycles per slot and a one-cycle blank between slots.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic               STOP,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic [3:0]         MASK,
  output logic               EN,
  output logic [1:0]         SEL,
  output logic               BUSY,
  output logic               WRAP
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic [1:0]         first_slot;
  logic [1:0]         next_slot;

  // Lowest enabled slot, used when a scan starts from IDLE.
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // First enabled slot strictly after cur, wrapping; cur itself is the last
  // candidate so a single-slot mask keeps returning the same slot.
  function automatic logic [1:0] slot_after(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] idx;
    r = cur;
    for (int i = 4; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  assign first_slot = lowest_set(MASK);
  assign next_slot  = slot_after(sel_q, MASK);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START && !STOP && (MASK != 4'b0000)) begin
          state_d = ACTIVE;
          sel_d   = first_slot;
          cnt_d   = DWELL;
        end
      end
      ACTIVE: begin
        if (STOP) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = BLANK;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      BLANK: begin
        if (STOP || (MASK == 4'b0000)) begin
          state_d = IDLE;
        end else begin
          state_d = ACTIVE;
          sel_d   = next_slot;
          cnt_d   = DWELL;
          wrap_d  = (next_slot <= sel_q);
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered copies of the next state so the decoder sees
    // SEL and EN change together on the same edge, never EN-high-while-moving.
    en_d   = (state_d == ACTIVE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign EN   = en_q;
  assign SEL  = sel_q;
  assign BUSY = busy_q;
  assign WRAP = wrap_q;

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the dwell-length input.
REQ-002 Port: CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 Port: START  input  1  request to begin scanning; sampled in IDLE only.
REQ-005 Port: STOP  input  1  request to abort scanning; sampled in every state.
REQ-006 Port: DWELL  input  DWELL_W  slot active length minus one, in clock cycles.
REQ-007 Port: MASK  input  4  per-slot enable; bit i=1 means slot i is included in the scan.
REQ-008 Port: EN  output  1  enable to the downstream 2-to-4 decoder; registered.
REQ-009 Port: SEL  output  2  slot index to the downstream 2-to-4 decoder; registered.
REQ-010 Port: BUSY  output  1  high in ACTIVE and BLANK states; registered.
REQ-011 Port: WRAP  output  1  one-cycle pulse marking completion of a full scan pass; registered.

Function
REQ-012 The block SHALL implement states IDLE, ACTIVE and BLANK; EN=1 only in ACTIVE.
REQ-013 IDLE: START=1, STOP=0 and MASK!=0 -> ACTIVE next cycle; SEL = lowest set MASK bit; dwell counter loaded with DWELL.
REQ-014 IDLE: START=1 with MASK=0 -> remain IDLE, no output change.
REQ-015 ACTIVE: dwell counter decrements each cycle; at count 0 -> BLANK next cycle; ACTIVE lasts exactly DWELL+1 cycles (DWELL=0 gives 1 cycle).
REQ-016 BLANK: exactly one cycle; EN=0, SEL held, BUSY=1 (anti-ghosting gap).
REQ-017 BLANK exit: next slot = next set MASK bit above current SEL, ascending, wrapping 3->0, skipping cleared bits; ACTIVE with counter reloaded from DWELL; MASK and DWELL sampled in the BLANK cycle.
REQ-018 If only one MASK bit is set, next slot = same slot (ACTIVE/BLANK alternate on one SEL).
REQ-019 WRAP SHALL pulse 1 for the single cycle entering ACTIVE when the new slot index is <= the previous slot index (wrap-around, including the single-slot case); otherwise 0.
REQ-020 MASK=0 sampled in BLANK -> IDLE next cycle; no WRAP.
REQ-021 STOP=1 in ACTIVE or BLANK -> IDLE next cycle, EN=0, BUSY=0, WRAP=0, SEL held; STOP has priority over all transitions.
REQ-022 STOP=1 and START=1 together in IDLE -> remain IDLE.
REQ-023 START in ACTIVE or BLANK SHALL be ignored.
REQ-024 SEL changes only on entry to ACTIVE; SEL is never changed in the same cycle that EN is 1 (no decoder glitch between slots).
REQ-025 DWELL changes mid-slot SHALL not affect the current slot's length.

Reset
REQ-026 RST_N=0 SHALL immediately force IDLE, EN=0, SEL=2'b00, BUSY=0, WRAP=0, dwell counter=0, regardless of CLK.
REQ-027 Reset asserted mid-ACTIVE SHALL drop EN within the reset assertion, without waiting for a clock edge; after release, the block waits in IDLE for START.

Verification
REQ-028 MASK=4'b1111, DWELL=2, START pulse -> SEL sequence 0,1,2,3,0 with EN high 3 cycles each, 1-cycle EN=0 gaps, WRAP high on the re-entry to SEL=0.
REQ-029 MASK=4'b1010, DWELL=0 -> EN pulses 1 cycle each on SEL=1,3,1,3; WRAP on each re-entry to SEL=1.
REQ-030 MASK=4'b0100, DWELL=1 -> SEL stays 2; EN 2 cycles high / 1 low, repeating; WRAP on every ACTIVE entry after the first.
REQ-031 STOP asserted on 2nd ACTIVE cycle of SEL=1 (MASK=4'b1111, DWELL=3) -> next cycle EN=0, BUSY=0, SEL=1; a later START restarts at SEL=0.
REQ-032 MASK cleared to 0 during ACTIVE (DWELL=2) -> slot completes, BLANK, then IDLE; no WRAP; START with MASK=0 -> stays IDLE.
REQ-033 RST_N pulsed low mid-ACTIVE between clock edges -> EN, BUSY, SEL, WRAP all 0 immediately; state IDLE after release.
